noc_inject_queue: RTL and testbench

Per-PE injection buffer between a traffic-generating PE's output port and the router's local input port. Absorbs bursts while the router backpressures, presents packets to the router in strict FIFO order, and keeps injection statistics (accepted, forwarded, router stall cycles, peak occupancy) for the end-of-run report. Packet fields are not modified.

---
 rtl/noc_inject_queue.sv | 114 +++++++++++
 tb/tb_noc_inject_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_queue.sv
// noc_inject_queue: per-PE injection FIFO between a traffic generator and the
// router's local input port, with injection statistics for end-of-run reports.
//
// Handshake (both sides, strict valid/ready): a transfer happens on a posedge
// where valid and ready are both 1. The producer keeps valid and data stable
// until that edge. The ready side here (o_ready) and the valid side here
// (o_valid) come only from registered state, so neither depends
// combinationally on i_valid or i_ready.
module noc_inject_queue #(
  parameter int data_width  = 240,
  parameter int dest_x      = 2,
  parameter int dest_y      = 2,
  parameter int source_x    = 8,
  parameter int source_y    = 8,
  parameter int total_width = dest_x + dest_y + source_x + source_y + data_width,
  parameter int depth       = 4,
  parameter int addr_w      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [total_width-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [addr_w:0]        o_occupancy,
  output logic [31:0]            o_in_count,
  output logic [31:0]            o_out_count,
  output logic [31:0]            o_stall_cycles,
  output logic [addr_w:0]        o_max_occupancy
);

  localparam logic [addr_w:0] LP_DEPTH = (addr_w + 1)'(depth);
  localparam logic [31:0]     LP_SAT   = 32'hFFFF_FFFF;

  logic [total_width-1:0] r_mem [depth];
  logic [addr_w-1:0]      r_wr_ptr;
  logic [addr_w-1:0]      r_rd_ptr;
  logic [addr_w:0]        r_count;
  logic [31:0]            r_in_count;
  logic [31:0]            r_out_count;
  logic [31:0]            r_stall_cycles;
  logic [addr_w:0]        r_max_occupancy;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_stall;
  logic [addr_w:0]        w_count_nxt;

  // Status decode and next occupancy; full blocks a push even when a pop
  // happens in the same cycle (no pass-through when full).
  always_comb begin
    w_full      = (r_count == LP_DEPTH);
    w_empty     = (r_count == '0);
    w_push      = i_valid & ~w_full;
    w_pop       = ~w_empty & i_ready;
    w_stall     = ~w_empty & ~i_ready;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Packet storage; not cleared by reset, and a push presented during the
  // reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at depth-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Saturating traffic counters and peak occupancy tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_count      <= '0;
      r_out_count     <= '0;
      r_stall_cycles  <= '0;
      r_max_occupancy <= '0;
    end else begin
      if (w_push && r_in_count != LP_SAT)     r_in_count     <= r_in_count + 32'd1;
      if (w_pop && r_out_count != LP_SAT)     r_out_count    <= r_out_count + 32'd1;
      if (w_stall && r_stall_cycles != LP_SAT) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_count_nxt > r_max_occupancy)      r_max_occupancy <= w_count_nxt;
    end
  end

  assign o_ready         = ~w_full;
  assign o_valid         = ~w_empty;
  assign o_data          = r_mem[r_rd_ptr];
  assign o_occupancy     = r_count;
  assign o_in_count      = r_in_count;
  assign o_out_count     = r_out_count;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_max_occupancy = r_max_occupancy;

endmodule

// File: tb/tb_noc_inject_queue.sv
// Bench for noc_inject_queue: a table of per-cycle vectors followed by
// hand-written streaming and mid-operation reset sequences.
module tb_noc_inject_queue;

  localparam int TW = 260;
  localparam int AW = 2;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [TW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [TW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic [AW:0]   o_occupancy;
  logic [31:0]   o_in_count;
  logic [31:0]   o_out_count;
  logic [31:0]   o_stall_cycles;
  logic [AW:0]   o_max_occupancy;

  noc_inject_queue dut (
    .clk            (clk),
    .rst            (rst),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_occupancy    (o_occupancy),
    .o_in_count     (o_in_count),
    .o_out_count    (o_out_count),
    .o_stall_cycles (o_stall_cycles),
    .o_max_occupancy(o_max_occupancy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Packet table indexed by tag; tag 5 is dest=(1,2) src=(0,0) payload=5.
  logic [TW-1:0] pkt_tab [32];

  function automatic logic [TW-1:0] make_pkt(int i);
    logic [239:0] pl;
    logic [7:0]   sx, sy;
    logic [1:0]   dx, dy;
    pl            = '0;
    pl[31:0]      = 32'(i);
    if (i != 5) begin
      pl[127:96]  = 32'hA5A5_5A5A ^ 32'(i * 13);
      pl[239:208] = 32'hC0DE_0000 | 32'(i);
    end
    sx = (i == 5) ? 8'd0 : 8'(i * 17 + 3);
    sy = (i == 5) ? 8'd0 : 8'(255 - i);
    dx = (i == 5) ? 2'd1 : 2'(i);
    dy = (i == 5) ? 2'd2 : 2'(i >> 2);
    return {pl, sy, sx, dy, dx};
  endfunction

  // Scoreboard helpers
  task automatic check_val(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_pkt(string name, logic [TW-1:0] act, int tag);
    n_checks++;
    if (act === pkt_tab[tag]) n_pass++;
    else $display("FAIL %s: got payload %0d (dest %0d,%0d) expected tag %0d", name,
                  act[TW-1:20], act[1:0], act[3:2], tag);
  endtask

  // Expected-output record: head = -1 means o_data is not checked.
  typedef struct {
    logic rst, iv, ir;
    int   tag;
    logic ev, er;
    int   occ, cin, cout, stall, cmax, head;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, int tag, logic ir, logic ev, logic er,
                              int occ, int cin, int cout, int stall, int cmax, int head);
    vec_t v;
    v.rst = r; v.iv = iv; v.tag = tag; v.ir = ir; v.ev = ev; v.er = er;
    v.occ = occ; v.cin = cin; v.cout = cout; v.stall = stall; v.cmax = cmax; v.head = head;
    return v;
  endfunction

  // Driver: present inputs at the negedge, sample outputs 1 ns later.
  task automatic drive(logic r, logic iv, int tag, logic ir);
    rst     = r;
    i_valid = iv;
    i_data  = pkt_tab[tag & 31];
    i_ready = ir;
  endtask

  task automatic check_all(string tn, logic ev, logic er, int occ, int cin, int cout,
                           int stall, int cmax, int head);
    check_val({tn, " o_valid"}, longint'(o_valid), longint'(ev));
    check_val({tn, " o_ready"}, longint'(o_ready), longint'(er));
    check_val({tn, " occupancy"}, longint'(o_occupancy), longint'(occ));
    check_val({tn, " in_count"}, longint'(o_in_count), longint'(cin));
    check_val({tn, " out_count"}, longint'(o_out_count), longint'(cout));
    check_val({tn, " stall"}, longint'(o_stall_cycles), longint'(stall));
    check_val({tn, " max_occ"}, longint'(o_max_occupancy), longint'(cmax));
    if (head >= 0) check_pkt({tn, " o_data"}, o_data, head);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [4:0] exp_q[$];
  int cin, cout, stall, cmax;

  initial begin
    for (int i = 0; i < 32; i++) pkt_tab[i] = make_pkt(i);

    // Reset then idle (10 cycles)
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0,0,0,0, 0,1, 0,0,0,0,0, -1));
    // Single packet, router ready
    vecs.push_back(mk(0,1,5,1, 0,1, 0,0,0,0,0, -1));
    vecs.push_back(mk(0,0,0,1, 1,1, 1,1,0,0,1,  5));
    vecs.push_back(mk(0,0,0,0, 0,1, 0,1,1,0,1, -1));
    // Fill under backpressure, payloads 0..5; PE holds 4 while full
    vecs.push_back(mk(0,1,0,0, 0,1, 0,1,1,0,1, -1));
    vecs.push_back(mk(0,1,1,0, 1,1, 1,2,1,0,1,  0));
    vecs.push_back(mk(0,1,2,0, 1,1, 2,3,1,1,2,  0));
    vecs.push_back(mk(0,1,3,0, 1,1, 3,4,1,2,3,  0));
    vecs.push_back(mk(0,1,4,0, 1,0, 4,5,1,3,4,  0));
    vecs.push_back(mk(0,1,4,0, 1,0, 4,5,1,4,4,  0));
    // Release: first cycle is full with simultaneous pop (push blocked)
    vecs.push_back(mk(0,1,4,1, 1,0, 4,5,1,5,4,  0));
    vecs.push_back(mk(0,1,4,1, 1,1, 3,5,2,5,4,  1));
    vecs.push_back(mk(0,1,5,1, 1,1, 3,6,3,5,4,  2));
    vecs.push_back(mk(0,0,0,1, 1,1, 3,7,4,5,4,  3));
    vecs.push_back(mk(0,0,0,1, 1,1, 2,7,5,5,4,  4));
    vecs.push_back(mk(0,0,0,1, 1,1, 1,7,6,5,4,  5));
    vecs.push_back(mk(0,0,0,0, 0,1, 0,7,7,5,4, -1));

    // Reset: rst high for two edges
    @(negedge clk);
    drive(1, 0, 0, 0);
    next_cycle();
    next_cycle();

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].iv, vecs[k].tag, vecs[k].ir);
      #1;
      check_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].er, vecs[k].occ, vecs[k].cin,
                vecs[k].cout, vecs[k].stall, vecs[k].cmax, vecs[k].head);
      next_cycle();
    end

    // Streaming at count=2: prime with tags 10, 11 under backpressure
    cin = 7; cout = 7; stall = 5; cmax = 4;
    drive(0, 1, 10, 0);
    #1 check_all("prime0", 0, 1, 0, cin, cout, stall, cmax, -1);
    next_cycle();
    cin++;
    drive(0, 1, 11, 0);
    #1 check_all("prime1", 1, 1, 1, cin, cout, stall, cmax, 10);
    next_cycle();
    cin++; stall++;
    exp_q.push_back(5'd10);
    exp_q.push_back(5'd11);
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 12 + k, 1);
      #1 check_all($sformatf("stream%0d", k), 1, 1, 2, cin, cout, stall, cmax, int'(exp_q[0]));
      next_cycle();
      void'(exp_q.pop_front());
      exp_q.push_back(5'(12 + k));
      cin++; cout++;
    end

    // Reset mid-operation: queue a third packet, then reset with push and pop
    drive(0, 1, 0, 0);
    #1 check_all("pre_rst", 1, 1, 2, cin, cout, stall, cmax, int'(exp_q[0]));
    next_cycle();
    cin++; stall++;
    drive(1, 1, 1, 1);
    #1 check_val("rst_cycle occupancy", longint'(o_occupancy), 3);
    next_cycle();
    drive(0, 1, 2, 0);
    #1 check_all("post_rst", 0, 1, 0, 0, 0, 0, 0, -1);
    next_cycle();
    drive(0, 0, 0, 0);
    #1 check_all("post_rst_push", 1, 1, 1, 1, 0, 0, 1, 2);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
